to_tx_axis: RTL and testbench

Ethernet transmit-side DMA engine: on a software send command it fetches a frame from memory with BedRock uncached 8-byte reads over the I/O command/response channel and streams it out as an AXI-Stream TX frame toward the MAC. It sits next to the RX path in the Ethernet block, uses the same `eth_cmd` register interface and exposes a 2-bit external state for the CSR view. Read issue is credit-limited by an internal response FIFO, so AXIS backpressure never drops data.

---
 rtl/to_tx_axis.sv | 212 +++++++++++++++++++++
 tb/tb_to_tx_axis.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/to_tx_axis.sv
// to_tx_axis: Ethernet TX DMA; fetches a frame with uncached 8-byte reads and
// streams it as AXIS. Optional 60-byte minimum padding: TO_TX_AXIS_MIN_PAD_EN.
module to_tx_axis #(
   parameter int paddr_width_p     = 40,
   parameter int lce_id_width_p    = 4,
   parameter int cce_block_width_p = 64,
   parameter int axis_data_width_p = 64,
   parameter int reg_addr_width_p  = paddr_width_p,
   parameter int eth_cmd_width_p   = 3,
   parameter int tx_fifo_els_p     = 4,
   parameter int tx_max_len_p      = 2048,
   localparam int hdr_width_lp = 11 + paddr_width_p + lce_id_width_p,
   localparam int cce_mem_msg_width_lp = hdr_width_lp + cce_block_width_p
) (
   input  logic                            clk_i,
   input  logic                            reset_n_i,
   input  logic [lce_id_width_p-1:0]       lce_id_i,
   input  logic [eth_cmd_width_p-1:0]      eth_cmd_i,
   input  logic                            eth_cmd_v_i,
   input  logic [reg_addr_width_p-1:0]     eth_cmd_arg_i,
   output logic [axis_data_width_p-1:0]    tx_axis_tdata_o,
   output logic [axis_data_width_p/8-1:0]  tx_axis_tkeep_o,
   output logic                            tx_axis_tvalid_o,
   input  logic                            tx_axis_tready_i,
   output logic                            tx_axis_tlast_o,
   output logic                            tx_axis_tuser_o,
   output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
   output logic                            io_cmd_v_o,
   input  logic                            io_cmd_yumi_i,
   input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
   input  logic                            io_resp_v_i,
   output logic                            io_resp_ready_o,
   output logic [1:0]                      tx_ext_state_o
);

   typedef enum logic [1:0] {
      S_INIT = 2'b00,
      S_SEND = 2'b01,
      S_DONE = 2'b10,
      S_IDLE = 2'b11
   } state_e;

   localparam int ptr_w_lp = (tx_fifo_els_p > 1) ? $clog2(tx_fifo_els_p) : 1;
   localparam int cnt_w_lp = ptr_w_lp + 1;
   localparam logic [cnt_w_lp:0] els_lp = (cnt_w_lp + 1)'(tx_fifo_els_p);
   localparam logic [15:0] max_len_lp = 16'(tx_max_len_p);
   localparam logic [eth_cmd_width_p-1:0] op_set_lp  = eth_cmd_width_p'(3);
   localparam logic [eth_cmd_width_p-1:0] op_send_lp = eth_cmd_width_p'(4);
   localparam logic [eth_cmd_width_p-1:0] op_ack_lp  = eth_cmd_width_p'(5);

   state_e                      state_q, state_d;
   logic [reg_addr_width_p-1:0] buf_addr_q, buf_addr_d;
   logic [15:0]                 len_q, len_d;
   logic [15:0]                 rd_idx_q, rd_idx_d;
   logic [15:0]                 beat_idx_q, beat_idx_d;
   logic [cnt_w_lp-1:0]         inflight_q, inflight_d;
   logic [cnt_w_lp-1:0]         count_q, count_d;
   logic [ptr_w_lp-1:0]         wptr_q, wptr_d;
   logic [ptr_w_lp-1:0]         rptr_q, rptr_d;
   logic [63:0]                 mem_q [tx_fifo_els_p];
   logic [63:0]                 mem_d [tx_fifo_els_p];

   logic [15:0] eff_len, beats, last_idx, arg_len;
   logic [3:0]  rem;
   logic [7:0]  last_keep;
   logic [reg_addr_width_p-1:0] rd_addr;
   logic cmd_set, cmd_send, cmd_ack, send_ok;
   logic push, pop, yumi, ret, is_last;
   logic unused_resp;

   always_comb begin
`ifdef TO_TX_AXIS_MIN_PAD_EN
      eff_len = (len_q < 16'd60) ? 16'd60 : len_q;
`else
      eff_len = len_q;
`endif
      beats     = (eff_len + 16'd7) >> 3;
      last_idx  = beats - 16'd1;
      rem       = {1'b0, eff_len[2:0] - 3'd1} + 4'd1;
      last_keep = 8'hFF >> (4'd8 - rem);
   end

   assign arg_len  = eth_cmd_arg_i[15:0];
   assign cmd_set  = eth_cmd_v_i && (eth_cmd_i == op_set_lp);
   assign cmd_send = eth_cmd_v_i && (eth_cmd_i == op_send_lp);
   assign cmd_ack  = eth_cmd_v_i && (eth_cmd_i == op_ack_lp);
   assign send_ok  = cmd_send && (arg_len != 16'd0) && (arg_len <= max_len_lp);

   // Credit check counts both outstanding reads and buffered beats.
   assign io_cmd_v_o = (state_q == S_SEND) && (rd_idx_q < beats)
      && (({1'b0, inflight_q} + {1'b0, count_q}) < els_lp);
   assign rd_addr = buf_addr_q + (reg_addr_width_p'(rd_idx_q) << 3);
   assign io_cmd_o = {{cce_block_width_p{1'b0}}, lce_id_i, 3'b011,
      paddr_width_p'(rd_addr), 4'b0000, 4'b0010};
   assign io_resp_ready_o = 1'b1;
   assign unused_resp = ^io_resp_i[hdr_width_lp-1:0];

   assign tx_axis_tvalid_o = (count_q != '0);
   assign is_last          = (beat_idx_q == last_idx);
   assign tx_axis_tlast_o  = tx_axis_tvalid_o && is_last;
   assign tx_axis_tkeep_o  = !tx_axis_tvalid_o ? 8'h00
                           : (is_last ? last_keep : 8'hFF);
   assign tx_axis_tuser_o  = 1'b0;
   assign tx_ext_state_o   = state_q;

   always_comb begin
      tx_axis_tdata_o = mem_q[rptr_q];
`ifdef TO_TX_AXIS_MIN_PAD_EN
      for (int k = 0; k < 8; k++) begin
         if (((beat_idx_q << 3) + 16'(k)) >= len_q)
            tx_axis_tdata_o[8*k +: 8] = 8'h00;
      end
`endif
   end

   // Stale responses are only accepted while a frame is active.
   assign push = io_resp_v_i && (state_q == S_SEND);
   assign ret  = push && (inflight_q != '0);
   assign pop  = tx_axis_tvalid_o && tx_axis_tready_i;
   assign yumi = io_cmd_yumi_i && io_cmd_v_o;

   always_comb begin
      state_d    = state_q;
      buf_addr_d = buf_addr_q;
      len_d      = len_q;
      rd_idx_d   = rd_idx_q;
      beat_idx_d = beat_idx_q;
      inflight_d = inflight_q;
      count_d    = count_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      mem_d      = mem_q;
      if (push) begin
         mem_d[wptr_q] = io_resp_i[hdr_width_lp +: 64];
         wptr_d = wptr_q + ptr_w_lp'(1);
      end
      if (pop) begin
         rptr_d     = rptr_q + ptr_w_lp'(1);
         beat_idx_d = beat_idx_q + 16'd1;
      end
      if (yumi)
         rd_idx_d = rd_idx_q + 16'd1;
      if (yumi && !ret)
         inflight_d = inflight_q + cnt_w_lp'(1);
      else if (!yumi && ret)
         inflight_d = inflight_q - cnt_w_lp'(1);
      if (push && !pop)
         count_d = count_q + cnt_w_lp'(1);
      else if (!push && pop)
         count_d = count_q - cnt_w_lp'(1);
      unique case (state_q)
         S_INIT: begin
            if (cmd_set) begin
               buf_addr_d = eth_cmd_arg_i;
               state_d    = S_IDLE;
            end
         end
         S_IDLE: begin
            if (cmd_set) begin
               buf_addr_d = eth_cmd_arg_i;
            end else if (send_ok) begin
               len_d      = arg_len;
               rd_idx_d   = '0;
               beat_idx_d = '0;
               inflight_d = '0;
               count_d    = '0;
               wptr_d     = '0;
               rptr_d     = '0;
               state_d    = S_SEND;
            end
         end
         S_SEND: begin
            if (pop && is_last)
               state_d = S_DONE;
         end
         S_DONE: begin
            if (cmd_ack)
               state_d = S_IDLE;
            else if (cmd_set)
               buf_addr_d = eth_cmd_arg_i;
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= S_INIT;
         buf_addr_q <= '0;
         len_q      <= '0;
         rd_idx_q   <= '0;
         beat_idx_q <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         mem_q      <= '{default: '0};
      end else begin
         state_q    <= state_d;
         buf_addr_q <= buf_addr_d;
         len_q      <= len_d;
         rd_idx_q   <= rd_idx_d;
         beat_idx_q <= beat_idx_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         mem_q      <= mem_d;
      end
   end

endmodule

// File: tb/tb_to_tx_axis.sv
// tb_to_tx_axis: randomized bench for the TX DMA with a frame-level
// reference model and a single-cycle memory responder.
`timescale 1ns/1ps
module tb_to_tx_axis;
   localparam int PW = 40, LW = 4, HW = 11 + PW + LW, MW = HW + 64;
   localparam logic [2:0] C_SET = 3'b011, C_SEND = 3'b100, C_ACK = 3'b101;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic [31:0] cyc;
   } beat_t;

   logic clk_i = 1'b0;
   logic reset_n_i = 1'b0;
   logic [LW-1:0] lce_id_i = 4'h9;
   logic [2:0] eth_cmd_i = '0;
   logic eth_cmd_v_i = 1'b0;
   logic [PW-1:0] eth_cmd_arg_i = '0;
   logic [63:0] tdata;
   logic [7:0] tkeep;
   logic tvalid, tlast, tuser;
   logic tready = 1'b0;
   logic [MW-1:0] io_cmd_o;
   logic [MW-1:0] io_resp_i = '0;
   logic io_cmd_v_o, io_resp_ready_o;
   logic io_cmd_yumi_i = 1'b0;
   logic io_resp_v_i = 1'b0;
   logic [1:0] ext;

   int checks = 0, errors = 0, cyc = 0;
   int yumi_mode = 0, resp_mode = 0, rdy_mode = 0, yumi_budget = -1;
   beat_t got_q[$];
   logic [PW-1:0] cmd_q[$];
   logic [PW-1:0] pend_q[$];
   logic [MW-1:0] first_cmd = '0;

   always #5 clk_i = ~clk_i;

   to_tx_axis dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .lce_id_i(lce_id_i),
      .eth_cmd_i(eth_cmd_i), .eth_cmd_v_i(eth_cmd_v_i),
      .eth_cmd_arg_i(eth_cmd_arg_i),
      .tx_axis_tdata_o(tdata), .tx_axis_tkeep_o(tkeep),
      .tx_axis_tvalid_o(tvalid), .tx_axis_tready_i(tready),
      .tx_axis_tlast_o(tlast), .tx_axis_tuser_o(tuser),
      .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o),
      .io_cmd_yumi_i(io_cmd_yumi_i), .io_resp_i(io_resp_i),
      .io_resp_v_i(io_resp_v_i), .io_resp_ready_o(io_resp_ready_o),
      .tx_ext_state_o(ext)
   );

   function automatic logic [7:0] memb(input logic [PW-1:0] a);
      return (a[7:0] * 8'd13) ^ a[15:8] ^ a[39:32] ^ 8'hA5;
   endfunction

   function automatic logic [63:0] memw(input logic [PW-1:0] a);
      logic [63:0] w;
      for (int j = 0; j < 8; j++) w[8*j +: 8] = memb(a + PW'(j));
      return w;
   endfunction

   // memory: accepts reads at negedge, answers in order from pend_q
   initial begin : responder
      logic [PW-1:0] a;
      forever begin
         @(negedge clk_i);
         io_resp_v_i = 1'b0;
         if (pend_q.size() > 0 && (resp_mode == 0 ||
             (resp_mode == 1 && $urandom_range(0, 2) == 0))) begin
            a = pend_q.pop_front();
            io_resp_i = {memw(a), HW'({$urandom(), $urandom()})};
            io_resp_v_i = 1'b1;
         end
         io_cmd_yumi_i = 1'b0;
         if (io_cmd_v_o && reset_n_i && yumi_budget != 0 && (yumi_mode == 0 ||
             (yumi_mode == 1 && $urandom_range(0, 3) != 0))) begin
            io_cmd_yumi_i = 1'b1;
            pend_q.push_back(io_cmd_o[8 +: PW]);
            cmd_q.push_back(io_cmd_o[8 +: PW]);
            if (cmd_q.size() == 1) first_cmd = io_cmd_o;
            if (yumi_budget > 0) yumi_budget--;
         end
      end
   end

   // AXIS sink: drives tready, logs beats, checks hold during stalls
   initial begin : sink
      beat_t prev;
      bit stall;
      stall = 0;
      prev = '0;
      forever begin
         @(negedge clk_i);
         cyc++;
         if (!reset_n_i) stall = 0;
         if (stall) begin
            checks++;
            if (tvalid !== 1'b1 || tdata !== prev.d || tkeep !== prev.k ||
                tlast !== prev.l) begin
               errors++;
               $display("FAIL stall_hold got v=%b d=%h k=%h l=%b want v=1 d=%h k=%h l=%b",
                  tvalid, tdata, tkeep, tlast, prev.d, prev.k, prev.l);
            end
         end
         tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 :
                  1'($urandom_range(0, 1));
         stall = tvalid && !tready;
         prev.d = tdata;
         prev.k = tkeep;
         prev.l = tlast;
         prev.cyc = cyc;
         if (tvalid && tready) got_q.push_back(prev);
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic send_cmd(input logic [2:0] op, input logic [PW-1:0] arg);
      @(negedge clk_i);
      eth_cmd_i = op;
      eth_cmd_arg_i = arg;
      eth_cmd_v_i = 1'b1;
      @(negedge clk_i);
      eth_cmd_v_i = 1'b0;
      eth_cmd_i = '0;
   endtask

   task automatic chk_ext(input logic [1:0] want, input string nm);
      checks++;
      if (ext !== want) begin
         errors++;
         $display("FAIL %s ext got %b want %b", nm, ext, want);
      end
   endtask

   task automatic wait_ext(input logic [1:0] want, input int limit, input string nm);
      int n = 0;
      while (ext !== want && n < limit) begin
         @(negedge clk_i);
         n++;
      end
      chk_ext(want, nm);
   endtask

   task automatic check_frame(input logic [PW-1:0] addr, input int len, input string nm);
      int eff, nb;
      beat_t e;
      logic [63:0] m;
`ifdef TO_TX_AXIS_MIN_PAD_EN
      eff = (len < 60) ? 60 : len;
`else
      eff = len;
`endif
      nb = (eff + 7) / 8;
      checks++;
      if (got_q.size() != nb) begin
         errors++;
         $display("FAIL %s beat_count got %0d want %0d", nm, got_q.size(), nb);
      end
      checks++;
      if (cmd_q.size() != nb) begin
         errors++;
         $display("FAIL %s read_count got %0d want %0d", nm, cmd_q.size(), nb);
      end
      for (int b = 0; b < nb && b < got_q.size(); b++) begin
         e = '0;
         m = '0;
         for (int j = 0; j < 8; j++) begin
            int off;
            off = 8 * b + j;
            if (off < eff) begin
               e.k[j] = 1'b1;
               m[8*j +: 8] = 8'hFF;
               e.d[8*j +: 8] = (off < len) ? memb(addr + PW'(off)) : 8'h00;
            end
         end
         e.l = (b == nb - 1);
         checks++;
         if ((got_q[b].d & m) !== e.d || got_q[b].k !== e.k || got_q[b].l !== e.l) begin
            errors++;
            $display("FAIL %s beat%0d got d=%h k=%h l=%b want d=%h k=%h l=%b", nm, b,
               got_q[b].d & m, got_q[b].k, got_q[b].l, e.d, e.k, e.l);
            break;
         end
      end
      for (int i = 0; i < nb && i < cmd_q.size(); i++) begin
         checks++;
         if (cmd_q[i] !== addr + PW'(8 * i)) begin
            errors++;
            $display("FAIL %s read%0d addr got %h want %h", nm, i, cmd_q[i], addr + PW'(8 * i));
            break;
         end
      end
   endtask

   task automatic start_frame(input logic [PW-1:0] addr, input int len);
      got_q.delete();
      cmd_q.delete();
      send_cmd(C_SET, addr);
      send_cmd(C_SEND, PW'(len));
   endtask

   task automatic finish_frame(input logic [PW-1:0] addr, input int len, input string nm);
      wait_ext(2'b10, 5000, {nm, "_done"});
      check_frame(addr, len, nm);
      send_cmd(C_ACK, '0);
      chk_ext(2'b11, {nm, "_ack"});
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_i);
      checks++;
      if ({tvalid, tlast, tkeep, io_cmd_v_o, ext, tuser, io_resp_ready_o} !== 15'b000000000000001) begin
         errors++;
         $display("FAIL reset_outs got v=%b l=%b k=%h cv=%b ext=%b u=%b rr=%b want 0/0/00/0/00/0/1",
            tvalid, tlast, tkeep, io_cmd_v_o, ext, tuser, io_resp_ready_o);
      end
      reset_n_i = 1'b1;
      send_cmd(C_SEND, 40'd64);
      chk_ext(2'b00, "init_ignores_send");
      checks++;
      if (io_cmd_v_o !== 1'b0) begin
         errors++;
         $display("FAIL init_no_read got %b want 0", io_cmd_v_o);
      end
      send_cmd(C_SET, 40'h1000);
      chk_ext(2'b11, "init_set_to_idle");
   endtask

   task automatic test_basic();
      logic [MW-1:0] exp_cmd;
      start_frame(40'h1000, 64);
      chk_ext(2'b01, "send_latency_state");
      checks++;
      if (io_cmd_v_o !== 1'b1) begin
         errors++;
         $display("FAIL send_latency_cmdv got %b want 1", io_cmd_v_o);
      end
      finish_frame(40'h1000, 64, "basic64");
      exp_cmd = {64'h0, lce_id_i, 3'b011, 40'h1000, 4'h0, 4'h2};
      checks++;
      if (first_cmd !== exp_cmd) begin
         errors++;
         $display("FAIL cmd_header got %h want %h", first_cmd, exp_cmd);
      end
      if (got_q.size() == 8) begin
         checks++;
         if (got_q[7].cyc - got_q[0].cyc !== 32'd7) begin
            errors++;
            $display("FAIL full_rate span got %0d want 7", got_q[7].cyc - got_q[0].cyc);
         end
      end
   endtask

   task automatic test_len61();
      start_frame(40'h1000, 61);
      finish_frame(40'h1000, 61, "len61");
      checks++;
      if (got_q.size() == 0 || got_q[got_q.size()-1].k !== 8'h1F) begin
         errors++;
         $display("FAIL len61_keep got %h want 1f",
            got_q.size() ? got_q[got_q.size()-1].k : 8'h00);
      end
   endtask

   task automatic test_backpressure();
      rdy_mode = 2;
      start_frame(40'h4000, 256);
      repeat (30) @(negedge clk_i);
      checks++;
      if (cmd_q.size() != 4) begin
         errors++;
         $display("FAIL bp_reads got %0d want 4", cmd_q.size());
      end
      checks++;
      if (io_cmd_v_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_cmdv got %b want 0", io_cmd_v_o);
      end
      rdy_mode = 0;
      finish_frame(40'h4000, 256, "bp256");
   endtask

   task automatic test_pad();
      int nb;
      logic [7:0] lk;
`ifdef TO_TX_AXIS_MIN_PAD_EN
      nb = 8; lk = 8'h0F;
`else
      nb = 6; lk = 8'h03;
`endif
      start_frame(40'h5008, 42);
      finish_frame(40'h5008, 42, "len42");
      checks++;
      if (got_q.size() != nb || got_q[got_q.size()-1].k !== lk) begin
         errors++;
         $display("FAIL len42_shape got n=%0d want n=%0d keep %h", got_q.size(), nb, lk);
      end
   endtask

   task automatic test_ignored();
      send_cmd(C_SEND, 40'd0);
      chk_ext(2'b11, "send0_ignored");
      send_cmd(C_SEND, 40'd4000);
      chk_ext(2'b11, "send4000_ignored");
      send_cmd(C_SEND, 40'd2049);
      chk_ext(2'b11, "send2049_ignored");
      rdy_mode = 2;
      start_frame(40'h6000, 128);
      send_cmd(C_SEND, 40'd16);
      send_cmd(C_SET, 40'h9000);
      send_cmd(C_ACK, '0);
      chk_ext(2'b01, "cmds_in_send_ignored");
      rdy_mode = 1; yumi_mode = 1; resp_mode = 1;
      finish_frame(40'h6000, 128, "no_restart");
      rdy_mode = 0; yumi_mode = 0; resp_mode = 0;
   endtask

   task automatic test_random();
      logic [PW-1:0] a;
      int len;
      for (int i = 0; i < 6; i++) begin
         a = PW'({$urandom(), $urandom()});
         len = $urandom_range(1, 300);
         rdy_mode = $urandom_range(0, 1);
         yumi_mode = $urandom_range(0, 1);
         resp_mode = $urandom_range(0, 1);
         start_frame(a, len);
         finish_frame(a, len, $sformatf("rand%0d_len%0d", i, len));
      end
      rdy_mode = 0; yumi_mode = 0; resp_mode = 0;
      start_frame(40'hFF_FFFF_FF00, 2048);
      finish_frame(40'hFF_FFFF_FF00, 2048, "max_len_wrap");
      start_frame(40'h0123, 1);
      finish_frame(40'h0123, 1, "len1");
   endtask

   task automatic test_reset_mid();
      int n = 0;
      resp_mode = 2;
      yumi_budget = 3;
      start_frame(40'h7000, 256);
      while (cmd_q.size() < 3 && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      @(negedge clk_i);
      checks++;
      if (cmd_q.size() != 3 || io_cmd_v_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_setup reads %0d cmdv %b want 3 1", cmd_q.size(), io_cmd_v_o);
      end
      reset_n_i = 1'b0;
      #1;
      checks++;
      if ({tvalid, tlast, tkeep, io_cmd_v_o, ext} !== 13'b0) begin
         errors++;
         $display("FAIL rst_async got v=%b l=%b k=%h cv=%b ext=%b want all 0",
            tvalid, tlast, tkeep, io_cmd_v_o, ext);
      end
      @(negedge clk_i);
      reset_n_i = 1'b1;
      yumi_budget = -1;
      resp_mode = 0;
      got_q.delete();
      repeat (6) @(negedge clk_i);
      checks++;
      if (got_q.size() != 0 || tvalid !== 1'b0) begin
         errors++;
         $display("FAIL late_resp_dropped got beats=%0d v=%b want 0 0", got_q.size(), tvalid);
      end
      chk_ext(2'b00, "rst_init");
      start_frame(40'h8000, 16);
      finish_frame(40'h8000, 16, "after_reset16");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len61();
      test_backpressure();
      test_pad();
      test_ignored();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
